// File: rtl/intdiv_sgn.sv
// Sign resolution for a radix-2 signed-digit (SD2) value: the sign comes from the most
// significant nonzero digit, else sign_prec. Optional macro INTDIV_SGN_HOLD_EN gates register updates with en.
module intdiv_sgn #(
    parameter int NDIG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2*NDIG-1:0] sgn_cur,
    input  logic              sign_prec,
    input  logic              en,
    output logic              out,
    output logic              out_q,
    output logic              zero_q
);

    logic [NDIG-1:0] dig_nz;
    logic [NDIG-1:0] dig_neg;
    logic            zero_comb;

    // Code 11 is -1; codes 01 and 10 are both +1, so only 11 is negative.
    generate
        for (genvar gi = 0; gi < NDIG; gi++) begin : g_dig
            assign dig_nz[gi]  = |sgn_cur[2*gi +: 2];
            assign dig_neg[gi] = &sgn_cur[2*gi +: 2];
        end
    endgenerate

    assign zero_comb = ~|dig_nz;

    // Scan from least to most significant so the highest nonzero digit wins.
    always_comb begin
        out = sign_prec;
        for (int i = 0; i < NDIG; i++) begin
            if (dig_nz[i]) begin
                out = dig_neg[i];
            end
        end
    end

`ifdef INTDIV_SGN_HOLD_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (en) begin
            out_q  <= out;
            zero_q <= zero_comb;
        end
    end
`else
    // In this build the registers are free-running and en is intentionally unused.
    logic unused_en;
    assign unused_en = en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            out_q  <= out;
            zero_q <= zero_comb;
        end
    end
`endif

endmodule

// File: tb/tb_intdiv_sgn.sv
// Directed bench for intdiv_sgn: one NDIG=1 and one NDIG=4 instance sharing clock, reset and enable.
module tb_intdiv_sgn;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b1;
    logic [1:0] sgn1 = 2'b00;
    logic       sp1 = 1'b0;
    logic [7:0] sgn4 = 8'h00;
    logic       sp4 = 1'b0;
    logic       out1, out_q1, zero_q1;
    logic       out4, out_q4, zero_q4;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    intdiv_sgn #(.NDIG(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .sgn_cur(sgn1), .sign_prec(sp1), .en(en),
        .out(out1), .out_q(out_q1), .zero_q(zero_q1)
    );

    intdiv_sgn #(.NDIG(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .sgn_cur(sgn4), .sign_prec(sp4), .en(en),
        .out(out4), .out_q(out_q4), .zero_q(zero_q4)
    );

    task automatic test_reset();
        sgn1 = 2'b11; sp1 = 1'b0;
        sgn4 = 8'h00; sp4 = 1'b1;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (out_q1 !== 1'b0) $display("FAIL reset_out_q1 got=%b exp=0", out_q1); else pass_cnt++;
        total_cnt++;
        if (zero_q1 !== 1'b0) $display("FAIL reset_zero_q1 got=%b exp=0", zero_q1); else pass_cnt++;
        total_cnt++;
        if (out_q4 !== 1'b0) $display("FAIL reset_out_q4 got=%b exp=0", out_q4); else pass_cnt++;
        total_cnt++;
        if (zero_q4 !== 1'b0) $display("FAIL reset_zero_q4 got=%b exp=0", zero_q4); else pass_cnt++;
        total_cnt++;
        if (out1 !== 1'b1) $display("FAIL reset_out1_live got=%b exp=1", out1); else pass_cnt++;
        total_cnt++;
        if (out4 !== 1'b1) $display("FAIL reset_out4_live got=%b exp=1", out4); else pass_cnt++;
        rst_n = 1'b1;
    endtask

    task automatic test_ndig1_zero();
        @(negedge clk);
        sgn1 = 2'b00; sp1 = 1'b0; #1;
        total_cnt++;
        if (out1 !== 1'b0) $display("FAIL n1_zero_sp0 got=%b exp=0", out1); else pass_cnt++;
        sp1 = 1'b1; #1;
        total_cnt++;
        if (out1 !== 1'b1) $display("FAIL n1_zero_sp1 got=%b exp=1", out1); else pass_cnt++;
    endtask

    task automatic test_ndig1_digits();
        logic [1:0] vs [4] = '{2'b11, 2'b01, 2'b10, 2'b00};
        logic       ps [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic       ex [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            sgn1 = vs[i]; sp1 = ps[i]; #1;
            total_cnt++;
            if (out1 !== ex[i])
                $display("FAIL n1_digit sgn=%b sp=%b got=%b exp=%b", vs[i], ps[i], out1, ex[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_ndig4_mixed();
        logic [7:0] vs [6] = '{8'b00_00_11_01, 8'b00_10_11_00, 8'b01_11_11_11,
                               8'b11_01_00_00, 8'b00_00_00_00, 8'b00_00_00_10};
        logic       ps [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic       ex [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            sgn4 = vs[i]; sp4 = ps[i]; #1;
            total_cnt++;
            if (out4 !== ex[i])
                $display("FAIL n4_mixed sgn=%b sp=%b got=%b exp=%b", vs[i], ps[i], out4, ex[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_ndig4_reg();
        logic [7:0] vs [3] = '{8'h00, 8'b00_00_00_11, 8'b00_00_00_01};
        logic       ps [3] = '{1'b1, 1'b0, 1'b1};
        logic       eq [3] = '{1'b1, 1'b1, 1'b0};
        logic       ez [3] = '{1'b1, 1'b0, 1'b0};
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            sgn4 = vs[i]; sp4 = ps[i];
            @(negedge clk);
            total_cnt++;
            if (out_q4 !== eq[i] || zero_q4 !== ez[i])
                $display("FAIL n4_reg sgn=%b sp=%b got out_q=%b zero_q=%b exp %b %b",
                         vs[i], ps[i], out_q4, zero_q4, eq[i], ez[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_async_reset();
        en = 1'b1;
        @(negedge clk);
        sgn4 = 8'h00; sp4 = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (out_q4 !== 1'b1) $display("FAIL ar_pre got=%b exp=1", out_q4); else pass_cnt++;
        #2 rst_n = 1'b0; #1;
        total_cnt++;
        if (out_q4 !== 1'b0 || zero_q4 !== 1'b0)
            $display("FAIL ar_clear got out_q=%b zero_q=%b exp 0 0", out_q4, zero_q4);
        else pass_cnt++;
        total_cnt++;
        if (out4 !== 1'b1) $display("FAIL ar_out_live got=%b exp=1", out4); else pass_cnt++;
        sp4 = 1'b0; #1;
        total_cnt++;
        if (out4 !== 1'b0) $display("FAIL ar_out_track got=%b exp=0", out4); else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (out_q4 !== 1'b0) $display("FAIL ar_hold_in_reset got=%b exp=0", out_q4); else pass_cnt++;
        sp4 = 1'b1; rst_n = 1'b1; #1;
        total_cnt++;
        if (out_q4 !== 1'b0) $display("FAIL ar_release_no_edge got=%b exp=0", out_q4); else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (out_q4 !== 1'b1 || zero_q4 !== 1'b1)
            $display("FAIL ar_resume got out_q=%b zero_q=%b exp 1 1", out_q4, zero_q4);
        else pass_cnt++;
    endtask

    task automatic test_enable();
        logic exp_held;
`ifdef INTDIV_SGN_HOLD_EN
        exp_held = 1'b0;
`else
        exp_held = 1'b1;
`endif
        @(negedge clk);
        en = 1'b1; sgn1 = 2'b00; sp1 = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (out_q1 !== 1'b0) $display("FAIL en_setup got=%b exp=0", out_q1); else pass_cnt++;
        en = 1'b0; sp1 = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (out_q1 !== exp_held) $display("FAIL en_low got=%b exp=%b", out_q1, exp_held); else pass_cnt++;
        en = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (out_q1 !== 1'b1) $display("FAIL en_high got=%b exp=1", out_q1); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [1:0] vs [5] = '{2'b11, 2'b01, 2'b00, 2'b10, 2'b00};
        logic       ps [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic       eq [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic       ez [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        en = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            sgn1 = vs[i]; sp1 = ps[i];
            @(negedge clk);
            total_cnt++;
            if (out_q1 !== eq[i] || zero_q1 !== ez[i])
                $display("FAIL b2b idx=%0d got out_q=%b zero_q=%b exp %b %b",
                         i, out_q1, zero_q1, eq[i], ez[i]);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_ndig1_zero();
        test_ndig1_digits();
        test_ndig4_mixed();
        test_ndig4_reg();
        test_async_reset();
        test_enable();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
